trax_move_applier: RTL and testbench

Applies one Trax move word to the board store, consuming moves in the same 22-bit format the valid-move generator produces. It decodes tile type, column and row, bounds-checks against the active board size, and reads the target and its four neighbours from a single-port board RAM. It then checks legality and writes the tile cell, and reports a status per move. It sits between the move selector/host input and the board memory.

---
 rtl/trax_move_applier.sv | 193 +++++++++++++++++++
 tb/tb_trax_move_applier.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trax_move_applier.sv
// Trax move applier: decodes one move word, bounds-checks it, reads the
// target cell and its four neighbours from a single-port board RAM, checks
// legality and writes the tile, reporting a per-move status.
module trax_move_applier #(
  parameter int unsigned MAX_ROW = 50,
  parameter int unsigned MAX_COL = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [21:0] move,
  input  logic [9:0]  m,
  input  logic [9:0]  n,
  output logic [11:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [2:0]  mem_rdata,
  output logic        mem_wr_en,
  output logic [2:0]  mem_wdata,
  output logic        done,
  output logic [1:0]  status,
  output logic [11:0] tiles_placed
);

  localparam int unsigned AW        = 12;
  localparam int unsigned CW        = 10;
  localparam int unsigned TILES_MAX = MAX_ROW * MAX_COL;

  localparam logic [CW-1:0] MAX_ROW_W  = CW'(MAX_ROW);
  localparam logic [CW-1:0] MAX_COL_W  = CW'(MAX_COL);
  localparam logic [CW-1:0] MAX_ROW_M1 = CW'(MAX_ROW - 1);
  localparam logic [CW-1:0] MAX_COL_M1 = CW'(MAX_COL - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(MAX_COL);
  localparam logic [AW-1:0] TILES_CAP  = AW'(TILES_MAX);

  localparam logic [1:0] ST_PLACED   = 2'b00;
  localparam logic [1:0] ST_BAD      = 2'b01;
  localparam logic [1:0] ST_OCCUPIED = 2'b10;
  localparam logic [1:0] ST_ISOLATED = 2'b11;

  typedef enum logic [3:0] {
    IDLE, BOUNDS, RD_TGT, RD_UP, RD_DN, RD_LF, RD_RT, EVAL, WRITE, RESP
  } state_t;

  state_t        state;
  logic [1:0]    tile_q;
  logic [CW-1:0] col_q;
  logic [CW-1:0] row_q;
  logic [CW-1:0] m_q;
  logic [CW-1:0] n_q;
  logic [2:0]    tgt_data;
  logic          nbr_any;

  logic [AW-1:0] tgt_addr;
  logic [AW-1:0] up_addr;
  logic [AW-1:0] dn_addr;
  logic [AW-1:0] lf_addr;
  logic [AW-1:0] rt_addr;
  logic          bounds_err;
  logic          up_ok;
  logic          dn_ok;
  logic          lf_ok;
  logic          rt_ok;
  logic          isolated;

  // Address, bounds and neighbour-presence decode from the latched move
  always_comb begin
    tgt_addr   = AW'(row_q) * ROW_STRIDE + AW'(col_q);
    up_addr    = tgt_addr - ROW_STRIDE;
    dn_addr    = tgt_addr + ROW_STRIDE;
    lf_addr    = tgt_addr - AW'(1);
    rt_addr    = tgt_addr + AW'(1);
    bounds_err = (tile_q == 2'b00) || (row_q >= n_q) || (row_q >= MAX_ROW_W) ||
                 (col_q >= m_q) || (col_q >= MAX_COL_W);
    up_ok      = (row_q != '0);
    dn_ok      = ((11'(row_q) + 11'd1) < 11'(n_q)) && (row_q < MAX_ROW_M1);
    lf_ok      = (col_q != '0);
    rt_ok      = ((11'(col_q) + 11'd1) < 11'(m_q)) && (col_q < MAX_COL_M1);
    // right neighbour data arrives in EVAL and is folded in directly
    isolated   = (tiles_placed != '0) && !nbr_any &&
                 !(rt_ok && (mem_rdata != 3'b000));
  end

  // Move sequencer with registered handshake, memory strobes and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      move_ready   <= 1'b0;
      done         <= 1'b0;
      status       <= ST_PLACED;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      tiles_placed <= '0;
      tile_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      m_q          <= '0;
      n_q          <= '0;
      tgt_data     <= '0;
      nbr_any      <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (move_valid && move_ready) begin
            tile_q     <= move[21:20];
            col_q      <= move[19:10];
            row_q      <= move[9:0];
            m_q        <= m;
            n_q        <= n;
            tgt_data   <= '0;
            nbr_any    <= 1'b0;
            move_ready <= 1'b0;
            state      <= BOUNDS;
          end else begin
            move_ready <= 1'b1;
          end
        end
        BOUNDS: begin
          if (bounds_err) begin
            status <= ST_BAD;
            done   <= 1'b1;
            state  <= RESP;
          end else begin
            mem_addr  <= tgt_addr;
            mem_rd_en <= 1'b1;
            state     <= RD_TGT;
          end
        end
        RD_TGT: begin
          mem_addr  <= up_ok ? up_addr : tgt_addr;
          mem_rd_en <= up_ok;
          state     <= RD_UP;
        end
        RD_UP: begin
          tgt_data  <= mem_rdata;
          mem_addr  <= dn_ok ? dn_addr : tgt_addr;
          mem_rd_en <= dn_ok;
          state     <= RD_DN;
        end
        RD_DN: begin
          if (up_ok && (mem_rdata != 3'b000)) nbr_any <= 1'b1;
          mem_addr  <= lf_ok ? lf_addr : tgt_addr;
          mem_rd_en <= lf_ok;
          state     <= RD_LF;
        end
        RD_LF: begin
          if (dn_ok && (mem_rdata != 3'b000)) nbr_any <= 1'b1;
          mem_addr  <= rt_ok ? rt_addr : tgt_addr;
          mem_rd_en <= rt_ok;
          state     <= RD_RT;
        end
        RD_RT: begin
          if (lf_ok && (mem_rdata != 3'b000)) nbr_any <= 1'b1;
          mem_addr <= tgt_addr;
          state    <= EVAL;
        end
        EVAL: begin
          if (tgt_data != 3'b000) begin
            status <= ST_OCCUPIED;
            done   <= 1'b1;
            state  <= RESP;
          end else if (isolated) begin
            status <= ST_ISOLATED;
            done   <= 1'b1;
            state  <= RESP;
          end else begin
            mem_addr  <= tgt_addr;
            mem_wdata <= {1'b0, tile_q};
            mem_wr_en <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (tiles_placed != TILES_CAP) tiles_placed <= tiles_placed + AW'(1);
          status <= ST_PLACED;
          done   <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          move_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trax_move_applier.sv
// Bench for trax_move_applier: behavioural board RAM, table-driven directed
// moves, hand-written multi-cycle sequences and random moves against a
// rule-level reference model.
module tb_trax_move_applier;

  localparam int MR  = 50;
  localparam int MC  = 50;
  localparam int CAP = MR * MC;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_valid;
  logic        move_ready;
  logic [21:0] move;
  logic [9:0]  m;
  logic [9:0]  n;
  logic [11:0] mem_addr;
  logic        mem_rd_en;
  logic [2:0]  mem_rdata = 3'b000;
  logic        mem_wr_en;
  logic [2:0]  mem_wdata;
  logic        done;
  logic [1:0]  status;
  logic [11:0] tiles_placed;

  always #5 clk = ~clk;

  trax_move_applier #(.MAX_ROW(MR), .MAX_COL(MC)) dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_ready(move_ready),
    .move(move), .m(m), .n(n), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .done(done), .status(status), .tiles_placed(tiles_placed)
  );

  // board RAM with one-cycle read latency and a bench preload port
  logic [2:0]  ram [0:4095] = '{default: 3'b000};
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [2:0]  poke_data = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    else if (poke_en) ram[poke_addr] <= poke_data;
  end

  // memory-bus activity log
  int rd_q[$];
  int wr_a_q[$];
  int wr_d_q[$];
  int both_cnt = 0;
  always @(negedge clk) begin
    if (mem_rd_en) rd_q.push_back(int'(mem_addr));
    if (mem_wr_en) begin
      wr_a_q.push_back(int'(mem_addr));
      wr_d_q.push_back(int'(mem_wdata));
    end
    if (mem_rd_en && mem_wr_en) both_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // reference model: board contents and successful-placement count
  logic [2:0] model_board [0:4095] = '{default: 3'b000};
  int model_tiles = 0;
  int exp_rd[$];
  int exp_st, exp_lat, exp_wa, exp_wd;
  bit exp_wr;

  task automatic model_move(input int tile, input int col, input int row,
                            input int mm, input int nn);
    int  tgt;
    bit  any;
    exp_rd.delete();
    exp_wr = 0;
    exp_wa = 0;
    exp_wd = 0;
    if (tile == 0 || row >= nn || row >= MR || col >= mm || col >= MC) begin
      exp_st  = 1;
      exp_lat = 2;
      return;
    end
    tgt = row * MC + col;
    any = 0;
    exp_rd.push_back(tgt);
    if (row > 0) begin
      exp_rd.push_back(tgt - MC);
      if (model_board[tgt - MC] != 0) any = 1;
    end
    if (row < nn - 1 && row < MR - 1) begin
      exp_rd.push_back(tgt + MC);
      if (model_board[tgt + MC] != 0) any = 1;
    end
    if (col > 0) begin
      exp_rd.push_back(tgt - 1);
      if (model_board[tgt - 1] != 0) any = 1;
    end
    if (col < mm - 1 && col < MC - 1) begin
      exp_rd.push_back(tgt + 1);
      if (model_board[tgt + 1] != 0) any = 1;
    end
    if (model_board[tgt] != 0) begin
      exp_st = 2; exp_lat = 8;
    end else if (model_tiles != 0 && !any) begin
      exp_st = 3; exp_lat = 8;
    end else begin
      exp_st = 0; exp_lat = 9;
      exp_wr = 1; exp_wa = tgt; exp_wd = tile;
    end
  endtask

  task automatic poke(input int a, input int v);
    poke_en   = 1'b1;
    poke_addr = 12'(a);
    poke_data = 3'(v);
    @(posedge clk); #1;
    poke_en = 1'b0;
    model_board[a] = 3'(v);
  endtask

  // apply one move and compare status, latency, bus traffic and counter
  task automatic run_move(input int tile, input int col, input int row,
                          input int mm, input int nn, input int e_st,
                          input int e_lat, input int e_tiles, input bit e_wr);
    int w, cyc, rb, wb;
    w = 0;
    while (move_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("ready_before_move", move_ready, 1);
    rb = rd_q.size();
    wb = wr_a_q.size();
    move       = {2'(tile), 10'(col), 10'(row)};
    m          = 10'(mm);
    n          = 10'(nn);
    move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    cyc = 1;
    check("ready_busy", move_ready, 0);
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("done_latency", cyc, e_lat);
    check("status", status, e_st);
    check("tiles_placed", tiles_placed, e_tiles);
    check("read_count", rd_q.size() - rb, exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      if (rb + i < rd_q.size()) check("read_addr", rd_q[rb + i], exp_rd[i]);
    check("write_count", wr_a_q.size() - wb, int'(e_wr));
    if (e_wr && wr_a_q.size() > wb) begin
      check("write_addr", wr_a_q[wb], exp_wa);
      check("write_data", wr_d_q[wb], exp_wd);
    end
    @(posedge clk); #1;
    check("done_pulse_width", done, 0);
    check("ready_after_resp", move_ready, 1);
    if (exp_wr) begin
      model_board[exp_wa] = 3'(exp_wd);
      if (model_tiles < CAP) model_tiles++;
    end
  endtask

  typedef struct {
    int tile, col, row, mm, nn;
    int pre_addr, pre_val;
    int e_st, e_lat, e_tiles;
    bit e_wr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cyc, first, second, st1, st2, rdy_resp, wb, seen_done;
    int tl, cl, rw, mm, nn;

    vecs[0]  = '{1,  0,  0,  1,  1,  -1, 0, 0, 9, 1, 1};
    vecs[1]  = '{2,  1,  0,  2,  1,  -1, 0, 0, 9, 2, 1};
    vecs[2]  = '{3,  5,  5, 10, 10,  -1, 0, 3, 8, 2, 0};
    vecs[3]  = '{1,  0,  2, 10, 10, 100, 3, 2, 8, 2, 0};
    vecs[4]  = '{0,  3,  3, 10, 10,  -1, 0, 1, 2, 2, 0};
    vecs[5]  = '{1,  3,  4, 10,  4,  -1, 0, 1, 2, 2, 0};
    vecs[6]  = '{1, 49,  0, 60, 60,  -1, 0, 3, 8, 2, 0};
    vecs[7]  = '{1, 50,  0, 60, 60,  -1, 0, 1, 2, 2, 0};
    vecs[8]  = '{1,  0, 50, 60, 60,  -1, 0, 1, 2, 2, 0};
    vecs[9]  = '{1,  1,  1, 10, 10,  -1, 0, 0, 9, 3, 1};
    vecs[10] = '{2,  9,  1, 10, 10,  -1, 0, 3, 8, 3, 0};
    vecs[11] = '{1,  0, 49, 60, 60, 2400, 1, 0, 9, 4, 1};

    rst = 1'b1; move_valid = 1'b0; move = '0; m = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_tiles", tiles_placed, 0);
    check("rst_ready", move_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", move_ready, 1);

    // directed table
    foreach (vecs[i]) begin
      if (vecs[i].pre_addr >= 0) poke(vecs[i].pre_addr, vecs[i].pre_val);
      model_move(vecs[i].tile, vecs[i].col, vecs[i].row, vecs[i].mm, vecs[i].nn);
      run_move(vecs[i].tile, vecs[i].col, vecs[i].row, vecs[i].mm, vecs[i].nn,
               vecs[i].e_st, vecs[i].e_lat, vecs[i].e_tiles, vecs[i].e_wr);
    end

    // reset in the middle of a legal placement
    wb = wr_a_q.size();
    seen_done = 0;
    move = {2'd1, 10'd2, 10'd1}; m = 10'd10; n = 10'd10;
    move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (done === 1'b1) seen_done = 1;
    check("midrst_ready", move_ready, 0);
    check("midrst_tiles", tiles_placed, 0);
    check("midrst_wr_en", mem_wr_en, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    if (done === 1'b1) seen_done = 1;
    check("midrst_ready_release", move_ready, 1);
    check("midrst_no_done", seen_done, 0);
    check("midrst_no_write", wr_a_q.size() - wb, 0);
    check("midrst_status", status, 0);
    model_tiles = 0;

    // first move after reset is exempt from the isolation rule
    model_move(1, 20, 20, 30, 30);
    run_move(1, 20, 20, 30, 30, 0, 9, 1, 1);

    // move_valid held through RESP: second accept only from IDLE
    model_move(2, 21, 20, 30, 30);
    wb = wr_a_q.size();
    first = -1; second = -1; st1 = -1; st2 = -1; rdy_resp = -1;
    move = {2'd2, 10'd21, 10'd20}; m = 10'd30; n = 10'd30;
    move_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc < 30 && second < 0) begin
      if (done === 1'b1) begin
        if (first < 0) begin
          first = cyc; st1 = int'(status); rdy_resp = int'(move_ready);
        end else begin
          second = cyc; st2 = int'(status);
        end
      end
      if (cyc == 11) move_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    move_valid = 1'b0;
    check("held_first_done", first, 9);
    check("held_first_status", st1, 0);
    check("held_ready_in_resp", rdy_resp, 0);
    check("held_second_done", second, 18);
    check("held_second_status", st2, 2);
    check("held_write_count", wr_a_q.size() - wb, 1);
    check("held_tiles", tiles_placed, 2);
    if (exp_wr) begin
      model_board[exp_wa] = 3'(exp_wd);
      model_tiles++;
    end
    @(posedge clk); #1;

    // random moves against the reference model
    for (int k = 0; k < 80; k++) begin
      tl = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        mm = int'($urandom_range(45, 60));
        nn = int'($urandom_range(45, 60));
      end else begin
        mm = int'($urandom_range(1, 12));
        nn = int'($urandom_range(1, 12));
      end
      cl = int'($urandom_range(0, mm));
      rw = int'($urandom_range(0, nn));
      model_move(tl, cl, rw, mm, nn);
      run_move(tl, cl, rw, mm, nn, exp_st, exp_lat,
               exp_wr ? ((model_tiles < CAP) ? model_tiles + 1 : CAP) : model_tiles,
               exp_wr);
    end

    check("rd_wr_exclusive", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
